prbs_scrambler: RTL and testbench



---
 rtl/prbs_pkg.sv | 36 +++
 rtl/prbs_lfsr_step.sv | 65 ++++++
 rtl/prbs_scrambler.sv | 109 ++++++++++
 tb/tb_prbs_scrambler.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// ============================================================================
// Module      : prbs_pkg
// Description : Shared constants for the PRBS scrambler family: standard
//               ITU-T PRBS polynomials/seeds and the mode/dir encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prbs_pkg;

   // Tap masks use bit (n-1) for the x^n term, so x^15+x^14+1 is bits 14 and 13.
   localparam int         PRBS7_W     = 7;
   localparam logic [6:0] PRBS7_POLY  = 7'h60;
   localparam logic [6:0] PRBS7_SEED  = 7'h7F;

   localparam int          PRBS15_W    = 15;
   localparam logic [14:0] PRBS15_POLY = 15'h6000;
   localparam logic [14:0] PRBS15_SEED = 15'h7FFF;

   localparam int          PRBS23_W    = 23;
   localparam logic [22:0] PRBS23_POLY = 23'h42_0000;
   localparam logic [22:0] PRBS23_SEED = 23'h7F_FFFF;

   localparam int          PRBS31_W    = 31;
   localparam logic [30:0] PRBS31_POLY = 31'h4800_0000;
   localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

   // Operating mode and direction encodings
   localparam logic MODE_ADDITIVE  = 1'b0;
   localparam logic MODE_SELF_SYNC = 1'b1;
   localparam logic DIR_SCRAMBLE   = 1'b0;
   localparam logic DIR_DESCRAMBLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/prbs_lfsr_step.sv
// ============================================================================
// Module      : prbs_lfsr_step
// Description : Combinational, fully unrolled DATA_W-step LFSR advance.
//               Bit 0 of data is processed first. Produces the scrambled
//               beat and the LFSR state after all DATA_W steps.
//               Self-synchronising feedback is only built when
//               PRBS_SCRAMBLER_SELF_SYNC_EN is defined; otherwise the
//               step is purely additive and mode/dir are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_lfsr_step
   import prbs_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = PRBS15_W,
   parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(PRBS15_POLY)
) (
   input  logic [LFSR_W-1:0] state,
   input  logic [DATA_W-1:0] data,
   input  logic              mode,
   input  logic              dir,
   output logic [LFSR_W-1:0] next_state,
   output logic [DATA_W-1:0] out_data
);

`ifndef PRBS_SCRAMBLER_SELF_SYNC_EN
   // Additive-only build: the configuration inputs have no effect.
   logic unused_cfg;
   assign unused_cfg = mode ^ dir;
`endif

   logic [LFSR_W-1:0] st;
   logic              fb;
   logic              shift_in;

   // Walk the LFSR DATA_W times, one input bit per step, in time order
   always_comb begin
      st       = state;
      out_data = '0;
      fb       = 1'b0;
      shift_in = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         fb          = ^(st & POLY);
         out_data[i] = data[i] ^ fb;
`ifdef PRBS_SCRAMBLER_SELF_SYNC_EN
         // Self-sync shifts in the scrambled bit, which is the output when
         // scrambling and the input when descrambling.
         if (mode == MODE_SELF_SYNC) begin
            shift_in = (dir == DIR_DESCRAMBLE) ? data[i] : out_data[i];
         end else begin
            shift_in = fb;
         end
`else
         shift_in = fb;
`endif
         st = {st[LFSR_W-2:0], shift_in};
      end
      next_state = st;
   end

endmodule

`default_nettype wire

// File: rtl/prbs_scrambler.sv
// ============================================================================
// Module      : prbs_scrambler
// Description : Parametrised LFSR scrambler/descrambler with valid/ready
//               stream interface, runtime seed load, lock-up (all-zero)
//               indication and a 16-bit accepted-beat counter.
//               Optional self-synchronising mode is enabled by defining
//               PRBS_SCRAMBLER_SELF_SYNC_EN; without it the block is always
//               additive and the mode/dir ports are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prbs_scrambler
   import prbs_pkg::*;
#(
   parameter int                DATA_W = 8,
   parameter int                LFSR_W = PRBS15_W,
   parameter logic [LFSR_W-1:0] POLY   = LFSR_W'(PRBS15_POLY),
   parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(PRBS15_SEED)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              mode,
   input  logic              dir,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [LFSR_W-1:0] lfsr_state,
   output logic              zero_state,
   output logic [15:0]       beat_cnt
);

   logic [LFSR_W-1:0] lfsr_reg;
   logic              zero_reg;
   logic [DATA_W-1:0] data_reg;
   logic              valid_reg;
   logic [15:0]       cnt_reg;

   logic [LFSR_W-1:0] step_state;
   logic [DATA_W-1:0] step_data;
   logic              accept;

   // A seed load owns the cycle, so no beat may be consumed alongside it.
   assign in_ready = !seed_load && (!valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   prbs_lfsr_step #(
      .DATA_W (DATA_W),
      .LFSR_W (LFSR_W),
      .POLY   (POLY)
   ) u_step (
      .state      (lfsr_reg),
      .data       (in_data),
      .mode       (mode),
      .dir        (dir),
      .next_state (step_state),
      .out_data   (step_data)
   );

   // LFSR state and its all-zero flag; advances only on accepted beats
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr_reg <= SEED;
         zero_reg <= 1'b0;
      end else if (seed_load) begin
         lfsr_reg <= seed;
         zero_reg <= (seed == '0);
      end else if (accept) begin
         lfsr_reg <= step_state;
         zero_reg <= (step_state == '0);
      end
   end

   // Output beat register: loads on accept, held while stalled downstream
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (accept) begin
         valid_reg <= 1'b1;
         data_reg  <= step_data;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

   // Accepted-beat counter, free-running wrap, unaffected by seed loads
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (accept) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign out_valid  = valid_reg;
   assign out_data   = data_reg;
   assign lfsr_state = lfsr_reg;
   assign zero_state = zero_reg;
   assign beat_cnt   = cnt_reg;

endmodule

`default_nettype wire

// File: tb/tb_prbs_scrambler.sv
// ============================================================================
// Module      : tb_prbs_scrambler
// Description : Self-checking bench for prbs_scrambler. A transmit instance
//               is checked beat by beat against a bit-history reference
//               model; a second instance descrambles the transmit output and
//               is checked against the original stream.
//               Self-sync scenario only runs with PRBS_SCRAMBLER_SELF_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prbs_scrambler;
   import prbs_pkg::*;

   localparam int          DATA_W = 8;
   localparam int          LFSR_W = PRBS15_W;
   localparam logic [14:0] POLY   = PRBS15_POLY;
   localparam logic [14:0] SEED   = PRBS15_SEED;
`ifdef PRBS_SCRAMBLER_SELF_SYNC_EN
   localparam bit SS_BUILD = 1'b1;
`else
   localparam bit SS_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        tx_seed_load, tx_mode, tx_dir, tx_in_valid, tx_in_ready;
   logic [14:0] tx_seed, tx_state;
   logic [7:0]  tx_in_data, tx_out_data;
   logic        tx_out_valid, tx_out_ready, tx_zero;
   logic [15:0] tx_cnt;

   logic        rx_seed_load, rx_mode, rx_dir, rx_in_valid, rx_in_ready;
   logic [14:0] rx_seed, rx_state;
   logic [7:0]  rx_in_data, rx_out_data;
   logic        rx_out_valid, rx_out_ready, rx_zero;
   logic [15:0] rx_cnt;

   logic tb_rdy;

   assign tx_out_ready = tb_rdy && rx_in_ready;
   assign rx_in_valid  = tx_out_valid && tb_rdy;
   assign rx_in_data   = tx_out_data;
   assign rx_out_ready = 1'b1;

   prbs_scrambler #(.DATA_W(DATA_W), .LFSR_W(LFSR_W), .POLY(POLY), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .seed_load(tx_seed_load), .seed(tx_seed),
      .mode(tx_mode), .dir(tx_dir), .in_valid(tx_in_valid), .in_ready(tx_in_ready),
      .in_data(tx_in_data), .out_valid(tx_out_valid), .out_ready(tx_out_ready),
      .out_data(tx_out_data), .lfsr_state(tx_state), .zero_state(tx_zero),
      .beat_cnt(tx_cnt)
   );

   prbs_scrambler #(.DATA_W(DATA_W), .LFSR_W(LFSR_W), .POLY(POLY), .SEED(SEED)) u_rx (
      .clk(clk), .rst_n(rst_n), .seed_load(rx_seed_load), .seed(rx_seed),
      .mode(rx_mode), .dir(rx_dir), .in_valid(rx_in_valid), .in_ready(rx_in_ready),
      .in_data(rx_in_data), .out_valid(rx_out_valid), .out_ready(rx_out_ready),
      .out_data(rx_out_data), .lfsr_state(rx_state), .zero_state(rx_zero),
      .beat_cnt(rx_cnt)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[k] is the bit that entered the register k steps ago; the feedback
   // is the XOR of the tapped history bits.
   bit hist[$];

   function automatic void model_load(input logic [14:0] s);
      hist.delete();
      for (int k = 0; k < LFSR_W; k++) hist.push_back(s[k]);
   endfunction

   function automatic logic [14:0] model_state();
      logic [14:0] r;
      r = '0;
      for (int k = 0; k < LFSR_W; k++) r[k] = hist[k];
      return r;
   endfunction

   function automatic logic [7:0] model_beat(input logic [7:0] din, input logic m, input logic d);
      logic [7:0] dout;
      bit fb, nb;
      dout = '0;
      for (int i = 0; i < DATA_W; i++) begin
         fb = 1'b0;
         for (int k = 0; k < LFSR_W; k++) if (POLY[k]) fb ^= hist[k];
         dout[i] = din[i] ^ fb;
         nb = fb;
         if (SS_BUILD && m) nb = d ? din[i] : dout[i];
         hist.push_front(nb);
         void'(hist.pop_back());
      end
      return dout;
   endfunction

   typedef struct {
      logic [7:0]  data;
      logic [14:0] st;
      logic [15:0] cnt;
      logic        zero;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] sent_q[$];
   int         model_cnt = 0;
   int         acc_cnt = 0;
   bit         rx_chk = 1'b0;
   int         rx_idx = 0;
   int         rx_skip = 0;

   // Acceptance observer: feeds the model and pushes expected responses
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         model_load(SEED);
         model_cnt = 0;
         exp_q.delete();
         sent_q.delete();
      end else if (tx_seed_load) begin
         model_load(tx_seed);
      end else if (tx_in_valid && tx_in_ready) begin
         e.data = model_beat(tx_in_data, tx_mode, tx_dir);
         model_cnt++;
         e.st   = model_state();
         e.cnt  = model_cnt[15:0];
         e.zero = (e.st == '0);
         exp_q.push_back(e);
         sent_q.push_back(tx_in_data);
         acc_cnt++;
      end
   end

   // Transmit monitor: one pop per delivered beat
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && tx_out_valid && tx_out_ready) begin
         if (exp_q.size() == 0) begin
            chk("tx_unexpected_beat", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_out_data, e.data);
            chk("tx_state", tx_state, e.st);
            chk("tx_cnt", tx_cnt, e.cnt);
            chk("tx_zero", tx_zero, e.zero);
         end
      end
   end

   // Receive monitor: descrambled beats must reproduce the original stream
   always @(negedge clk) begin
      logic [7:0] v;
      if (rst_n && rx_chk && rx_out_valid) begin
         if (sent_q.size() == 0) begin
            chk("rx_unexpected_beat", 32'd1, 32'd0);
         end else begin
            v = sent_q.pop_front();
            if (rx_idx >= rx_skip) chk("rx_data", rx_out_data, v);
            rx_idx++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      tx_in_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic drain();
      tx_in_valid = 1'b0;
      tb_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   // Hold downstream off for 5 cycles with a pending beat and input offered
   task automatic stall_test();
      logic [7:0]  rec_d;
      logic [14:0] rec_s;
      tx_in_valid = 1'b1;
      tx_in_data  = 8'($urandom);
      tb_rdy      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rec_d = tx_out_data;
      rec_s = tx_state;
      for (int c = 0; c < 5; c++) begin
         chk("stall_valid", tx_out_valid, 1'b1);
         chk("stall_in_ready", tx_in_ready, 1'b0);
         chk("stall_data", tx_out_data, rec_d);
         chk("stall_state", tx_state, rec_s);
         @(negedge clk);
      end
   endtask

   initial begin
      tx_seed_load = 0; tx_seed = '0; tx_mode = 0; tx_dir = 0;
      tx_in_valid = 0; tx_in_data = '0;
      rx_seed_load = 0; rx_seed = '0; rx_mode = 0; rx_dir = 0;
      tb_rdy = 1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_out_valid", tx_out_valid, 1'b0);
      chk("rst_out_data", tx_out_data, 8'h00);
      chk("rst_state", tx_state, SEED);
      chk("rst_zero", tx_zero, 1'b0);
      chk("rst_cnt", tx_cnt, 16'h0);

      // Seed load together with a valid beat: the beat waits one cycle
      @(posedge clk); #1;
      tx_seed_load = 1'b1; tx_seed = 15'h4000;
      tx_in_valid = 1'b1; tx_in_data = 8'h00;
      @(negedge clk);
      chk("seedload_in_ready", tx_in_ready, 1'b0);
      @(posedge clk); #1 tx_seed_load = 1'b0;
      @(negedge clk);
      chk("post_seed_state", tx_state, 15'h4000);
      chk("post_seed_in_ready", tx_in_ready, 1'b1);
      @(posedge clk); #1;
      tx_in_data = 8'h00;
      @(negedge clk);
      chk("seed4000_out", tx_out_data, 8'h01);
      chk("seed4000_state", tx_state, 15'h0080);
      @(posedge clk); #1;
      drain();

      // All-zero state: data passes through and the LFSR stays at zero
      tx_seed_load = 1'b1; tx_seed = 15'h0000;
      @(posedge clk); #1 tx_seed_load = 1'b0;
      @(negedge clk);
      chk("zero_flag", tx_zero, 1'b1);
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
         tx_in_valid = 1'b1;
         tx_in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      drain();
      chk("zero_stays", tx_state, 15'h0000);

      // Additive loopback with random valid/ready and one long stall
      do_reset();
      rx_chk = 1'b1; rx_idx = 0; rx_skip = 0;
      acc_cnt = 0;
      begin
         bit stalled = 1'b0;
         bit done = 1'b0;
         for (int cyc = 0; cyc < 8000; cyc++) begin
            @(posedge clk); #1;
            if (acc_cnt >= 1000) begin
               done = 1'b1;
               break;
            end
            if (acc_cnt >= 500 && !stalled) begin
               stalled = 1'b1;
               stall_test();
            end else begin
               tx_in_valid = ($urandom_range(0, 9) < 8);
               tx_in_data  = 8'($urandom);
               tb_rdy      = ($urandom_range(0, 3) != 0);
            end
         end
         if (!done) chk("loopback_timeout", 32'(acc_cnt), 32'd1000);
      end
      drain();
      chk("loop_tx_cnt", tx_cnt, 16'd1000);
      chk("loop_rx_cnt", rx_cnt, 16'd1000);
      chk("loop_exp_left", 32'(exp_q.size()), 32'd0);
      chk("loop_sent_left", 32'(sent_q.size()), 32'd0);

`ifdef PRBS_SCRAMBLER_SELF_SYNC_EN
      // Self-sync: a wrongly seeded descrambler recovers after LFSR_W bits
      rx_chk = 1'b0;
      do_reset();
      tx_mode = MODE_SELF_SYNC; tx_dir = DIR_SCRAMBLE;
      rx_mode = MODE_SELF_SYNC; rx_dir = DIR_DESCRAMBLE;
      rx_seed_load = 1'b1; rx_seed = 15'h1234;
      @(posedge clk); #1 rx_seed_load = 1'b0;
      @(negedge clk);
      chk("rx_seed_state", rx_state, 15'h1234);
      rx_idx = 0; rx_skip = 2; rx_chk = 1'b1;
      @(posedge clk); #1;
      for (int b = 0; b < 40; b++) begin
         tx_in_valid = 1'b1;
         tx_in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      drain();
      chk("ss_rx_beats", 32'(rx_idx), 32'd40);
      tx_mode = MODE_ADDITIVE; rx_mode = MODE_ADDITIVE;
      tx_dir = DIR_SCRAMBLE; rx_dir = DIR_SCRAMBLE;
`endif

      // Reset while a beat is pending and downstream is stalled
      rx_chk = 1'b0;
      tx_in_valid = 1'b1; tx_in_data = 8'($urandom); tb_rdy = 1'b0;
      @(posedge clk); #1 tx_in_valid = 1'b0;
      @(negedge clk);
      chk("prerst_valid", tx_out_valid, 1'b1);
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("midrst_valid", tx_out_valid, 1'b0);
      chk("midrst_state", tx_state, SEED);
      chk("midrst_cnt", tx_cnt, 16'h0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
